ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
CPU-to-keyboard PS/2 host transmitter. It sends command bytes such as LED set (0xED), reset (0xFF) and typematic settings to the keyboard over the bidirectional PS/2 clock and data lines. It is memory-mapped next to the keyboard scancode buffer in the 0x3xxxx MMIO region. It implements the full host-to-device frame: clock inhibit, request-to-send, start bit, 8 data bits, odd parity, stop bit and device ACK, with timeout and error reporting.

Parameters:
INHIBIT_CYCLES, 10000, clk_in cycles ps2_clk is held low before request-to-send (100 us at 100 MHz)
TIMEOUT_CYCLES, 1500000, maximum clk_in cycles between device clock falling edges before abort (15 ms)
TX_DATA_ADDR, 20'h30084, address of the transmit data register, compared against cpu_addr_in[19:0]
STATUS_ADDR, 20'h30088, address of the status register, compared against cpu_addr_in[19:0]

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
ps2_clk_in  input  1  raw PS/2 clock pin level (asynchronous)
ps2_data_in  input  1  raw PS/2 data pin level (asynchronous)
ps2_clk_oe_out  output  1  1 = drive PS/2 clock low; 0 = release (open-drain)
ps2_data_oe_out  output  1  1 = drive PS/2 data low; 0 = release
rx_inhibit_out  output  1  high whenever the FSM is not IDLE; the scancode receiver ignores line activity while high
cpu_addr_in  input  32  CPU MMIO address
cpu_write_enable_in  input  4  byte write enables; only bit 0 is used
cpu_data_in  input  32  CPU write data
cpu_data_out  output  32  combinational read data; 0 unless the address matches one of this block's registers

Behaviour:
- Synchronisation: ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer. A falling edge (fall) is the synchronized clock going 1 then 0 on consecutive cycles.
- Reset (asynchronous): state = IDLE; both oe outputs = 0; status flags = 0; shift register = 0; counters = 0; rx_inhibit_out = 0.
- Register map:
  - TX_DATA write: accepted only when state == IDLE. The accepted write latches cpu_data_in[7:0] and enters INHIBIT on the next cycle.
  - A TX_DATA write when state != IDLE is dropped and sets the overrun flag.
  - STATUS read: bit0 busy (state != IDLE), bit1 ack_ok, bit2 error, bit3 overrun; bits 31:4 = 0.
  - STATUS write (any data): clears bits 1-3. If a flag is set and cleared in the same cycle, the set wins.
  - Reads of TX_DATA return 0.
- Parity: odd. The parity bit is ~^data[7:0].
- FSM states and transitions:
  - IDLE: both lines released. An accepted write goes to INHIBIT and clears ack_ok and error.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYCLES cycles, then go to RTS.
  - RTS: data_oe = 1 and clk_oe = 0 on the same cycle (start bit). Go to DATA, bit index = 0, and start the timeout counter.
  - DATA: on each fall, drive data_oe = ~data[idx] and increment idx. On the fall where idx reaches 7, go to PARITY.
  - PARITY: on fall, data_oe = ~parity, then go to STOP.
  - STOP: on fall, data_oe = 0 (release, stop bit = 1), then go to ACK.
  - ACK: on fall, sample synchronized data. 0 sets ack_ok; 1 sets error (NACK). Go to WAIT_RELEASE.
  - WAIT_RELEASE: when both synchronized lines are 1, go to IDLE.
- Timeout:
  - The counter is reset on every fall and counts in RTS through WAIT_RELEASE.
  - On reaching TIMEOUT_CYCLES: set error, release both lines, go to IDLE.
- Completion and new writes: a TX_DATA write in the same cycle as the WAIT_RELEASE-to-IDLE transition is still refused (busy is registered) and sets overrun.
- Reset mid-frame: lines are released immediately and the partial frame is abandoned. The device times out on its own.
- Counter widths: $clog2 of the respective parameter plus 1.

Decomposition:
- ps2_pkg holds:
  - state enum ps2_tx_state_t (IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, WAIT_RELEASE)
  - address constants KB_TX_DATA_ADDR and KB_STATUS_ADDR
  - status bit index constants
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge pulse, with asynchronous reset to 1. It is instantiated twice; the fall output is used only for the clock instance.

Test Plan:
- Bench parameters: INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 200. The device model clocks at a 10-cycle period.
- Write 0xED to 0x30084, device ACKs:
  - clk_oe held 20 cycles, then the start bit (data_oe = 1)
  - bits sampled by the device LSB first are 1,0,1,1,0,1,1,1, then parity 1, then stop 1
  - STATUS reads 0x2 after WAIT_RELEASE
- Write 0xF4, device answers NACK (data high at the ACK slot) -> STATUS = 0x4, lines released, busy = 0.
- Write 0xFF, device never clocks -> 200 cycles after RTS, error set, both oe = 0, state IDLE, STATUS = 0x4.
- Write 0x11, then write 0x22 during DATA -> device receives 0x11 only; STATUS = 0xA after ACK; STATUS write clears to 0x0.
- Assert rst_in in the middle of DATA bit 4 -> both oe = 0 in the same cycle (asynchronous), STATUS = 0; a following write of 0xED completes normally.
- Read 0x30080 and 0x30000 -> cpu_data_out = 0. rx_inhibit_out is 1 exactly while busy.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_RELEASE
  } ps2_tx_state_t;

  localparam logic [19:0] KB_TX_DATA_ADDR = 20'h30084;
  localparam logic [19:0] KB_STATUS_ADDR  = 20'h30088;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_ACK_OK  = 1;
  localparam int unsigned STAT_ERROR   = 2;
  localparam int unsigned STAT_OVERRUN = 3;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for a raw PS/2 pin with a one-cycle falling-edge pulse.
// Resets to 1, the idle level of an open-drain PS/2 line.
module ps2_line_sync (
  input  logic clk_in,
  input  logic rst_in,
  input  logic line_in,
  output logic line_sync_out,
  output logic fall_out
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_sync_out = sync_q;
  assign fall_out      = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter with memory-mapped data and status registers.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter logic [19:0] TX_DATA_ADDR   = KB_TX_DATA_ADDR,
  parameter logic [19:0] STATUS_ADDR    = KB_STATUS_ADDR
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2_clk_oe_out,
  output logic        ps2_data_oe_out,
  output logic        rx_inhibit_out,
  input  logic [31:0] cpu_addr_in,
  input  logic [3:0]  cpu_write_enable_in,
  input  logic [31:0] cpu_data_in,
  output logic [31:0] cpu_data_out
);

  localparam int unsigned IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;
  logic wr_tx, wr_stat, busy, counting, timeout;
  logic unused_bits;

  ps2_line_sync u_clk_sync (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .line_in       (ps2_clk_in),
    .line_sync_out (clk_sync),
    .fall_out      (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .line_in       (ps2_data_in),
    .line_sync_out (data_sync),
    .fall_out      (data_fall_unused)
  );

  assign unused_bits = ^{cpu_addr_in[31:20], cpu_write_enable_in[3:1], cpu_data_in[31:8]};

  assign wr_tx    = cpu_write_enable_in[0] && (cpu_addr_in[19:0] == TX_DATA_ADDR);
  assign wr_stat  = cpu_write_enable_in[0] && (cpu_addr_in[19:0] == STATUS_ADDR);
  assign busy     = (state_q != IDLE);
  assign counting = (state_q != IDLE) && (state_q != INHIBIT);
  assign timeout  = counting && !clk_fall && (to_q == TO_LAST);

  assign ps2_clk_oe_out  = clk_oe_q;
  assign ps2_data_oe_out = data_oe_q;
  assign rx_inhibit_out  = busy;

  // State, datapath and status register update.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      inh_q     <= '0;
      to_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      inh_q     <= inh_d;
      to_q      <= to_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state logic; line drive values are computed one cycle ahead so the
  // registered oe outputs change on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    inh_d     = inh_q;
    to_d      = to_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q & ~wr_stat;
    err_d     = err_q & ~wr_stat;
    ovr_d     = ovr_q & ~wr_stat;

    if (wr_tx && busy) begin
      ovr_d = 1'b1;
    end

    if (counting) begin
      to_d = clk_fall ? '0 : to_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (wr_tx) begin
          shift_d  = cpu_data_in[7:0];
          idx_d    = '0;
          inh_d    = '0;
          to_d     = '0;
          ack_d    = 1'b0;
          err_d    = 1'b0;
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = RTS;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      RTS: begin
        idx_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[idx_q];
          if (idx_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (clk_fall) begin
          data_oe_d = ^shift_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (clk_fall) begin
          data_oe_d = 1'b0;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (clk_fall) begin
          if (!data_sync) begin
            ack_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (clk_sync && data_sync) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout) begin
      err_d     = 1'b1;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      state_d   = IDLE;
    end
  end

  // Register read mux; only STATUS returns data.
  always_comb begin
    cpu_data_out = '0;
    if (cpu_addr_in[19:0] == STATUS_ADDR) begin
      cpu_data_out[STAT_BUSY]    = busy;
      cpu_data_out[STAT_ACK_OK]  = ack_q;
      cpu_data_out[STAT_ERROR]   = err_q;
      cpu_data_out[STAT_OVERRUN] = ovr_q;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 keyboard model.
module tb_ps2_host_tx;

  localparam logic [31:0] TX_ADDR = 32'h0003_0084;
  localparam logic [31:0] ST_ADDR = 32'h0003_0088;

  typedef struct {
    logic [7:0] data;
    logic       par;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dev_clk_low = 1'b0;
  logic        dev_data_low = 1'b0;
  logic        ps2_clk_line, ps2_data_line;
  logic        clk_oe, data_oe, rx_inh;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic [31:0] rdata;
  logic [3:0]  cpu_we = '0;

  frame_t      exp_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int          dev_mode = 0;   // 0 = ACK, 1 = NACK, 2 = silent
  int          dev_k = -1;
  logic        dev_active = 1'b0;

  assign ps2_clk_line  = ~(clk_oe | dev_clk_low);
  assign ps2_data_line = ~(data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .TIMEOUT_CYCLES (200)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .ps2_clk_in          (ps2_clk_line),
    .ps2_data_in         (ps2_data_line),
    .ps2_clk_oe_out      (clk_oe),
    .ps2_data_oe_out     (data_oe),
    .rx_inhibit_out      (rx_inh),
    .cpu_addr_in         (cpu_addr),
    .cpu_write_enable_in (cpu_we),
    .cpu_data_in         (cpu_data),
    .cpu_data_out        (rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] b);
    frame_t f;
    f.data = b;
    f.par  = ($countones(b) % 2 == 0);
    exp_q.push_back(f);
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 cpu_addr = a; cpu_data = d; cpu_we = 4'h1;
    @(posedge clk);
    #1 cpu_we = 4'h0; cpu_addr = '0;
  endtask

  task automatic read_expect(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    cpu_addr = a;
    #1 check(name, rdata, exp);
    cpu_addr = '0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (rx_inh && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rx_inh) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic send(input logic [7:0] b);
    push_frame(b);
    cpu_write(TX_ADDR, {24'h0, b});
  endtask

  // Keyboard model: 10-cycle clock, samples on the rising edge, also acts as the frame monitor.
  task automatic run_frame();
    logic [9:0] bits;
    logic       aborted;
    frame_t     e;
    bits       = '0;
    aborted    = 1'b0;
    dev_active = 1'b1;
    repeat (4) @(negedge clk);
    check("start_bit", {31'h0, ps2_data_line}, 32'h0);
    for (int k = 0; k < 11 && !aborted; k++) begin
      dev_k = k;
      if (k == 10 && dev_mode == 0) begin
        dev_data_low = 1'b1;
        repeat (2) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (rst) aborted = 1'b1;
      end
      if (k < 10) bits[k] = ps2_data_line;
      dev_clk_low = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (rst) aborted = 1'b1;
      end
    end
    dev_data_low = 1'b0;
    dev_k = -1;
    if (!aborted) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_unexpected: got 0x%0h, expected no frame", bits[7:0]);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", {24'h0, bits[7:0]}, {24'h0, e.data});
        check("frame_parity", {31'h0, bits[8]}, {31'h0, e.par});
        check("frame_stop", {31'h0, bits[9]}, 32'h1);
      end
    end
    dev_active = 1'b0;
  endtask

  initial begin : device
    forever begin
      @(negedge clk);
      if (!rst && data_oe && !clk_oe && dev_mode != 2 && !dev_active) run_frame();
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin : stimulus
    int          n;
    int          m;
    logic [7:0]  b;
    int          mode;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_clk_oe", {31'h0, clk_oe}, 32'h0);
    check("reset_data_oe", {31'h0, data_oe}, 32'h0);
    check("reset_rx_inhibit", {31'h0, rx_inh}, 32'h0);
    rst = 1'b0;
    read_expect("reset_status", ST_ADDR, 32'h0);
    read_expect("read_30080", 32'h0003_0080, 32'h0);
    read_expect("read_30000", 32'h0003_0000, 32'h0);
    read_expect("read_tx_data", TX_ADDR, 32'h0);

    // 0xED with ACK: inhibit length, start bit, busy, final status.
    dev_mode = 0;
    send(8'hED);
    n = 0;
    @(negedge clk);
    while (clk_oe && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, 20);
    check("rts_data_oe", {31'h0, data_oe}, 32'h1);
    check("rts_clk_oe", {31'h0, clk_oe}, 32'h0);
    read_expect("status_busy", ST_ADDR, 32'h1);
    check("rx_inhibit_busy", {31'h0, rx_inh}, 32'h1);
    wait_idle("ed_ack_idle", 400);
    read_expect("status_ack", ST_ADDR, 32'h2);
    check("rx_inhibit_idle", {31'h0, rx_inh}, 32'h0);

    // 0xF4 with NACK.
    dev_mode = 1;
    send(8'hF4);
    wait_idle("f4_nack_idle", 400);
    read_expect("status_nack", ST_ADDR, 32'h4);
    check("nack_clk_oe", {31'h0, clk_oe}, 32'h0);
    check("nack_data_oe", {31'h0, data_oe}, 32'h0);

    // 0xFF with a silent device: abort 200 cycles after request-to-send.
    dev_mode = 2;
    cpu_write(TX_ADDR, 32'hFF);
    n = 0;
    while (!data_oe && n < 100) begin
      @(negedge clk);
      n++;
    end
    m = 0;
    while (data_oe && m < 400) begin
      m++;
      @(negedge clk);
    end
    check("timeout_len", m, 200);
    check("timeout_clk_oe", {31'h0, clk_oe}, 32'h0);
    check("timeout_data_oe", {31'h0, data_oe}, 32'h0);
    check("timeout_rx_inhibit", {31'h0, rx_inh}, 32'h0);
    read_expect("status_timeout", ST_ADDR, 32'h4);
    dev_mode = 0;

    // 0x11 then 0x22 mid-frame: only 0x11 goes out, overrun flagged.
    send(8'h11);
    n = 0;
    while (dev_k < 2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    cpu_write(TX_ADDR, 32'h22);
    wait_idle("overrun_idle", 400);
    read_expect("status_overrun", ST_ADDR, 32'hA);
    cpu_write(ST_ADDR, 32'hFFFF_FFFF);
    read_expect("status_cleared", ST_ADDR, 32'h0);

    // Reset in the middle of data bit 4.
    send(8'hED);
    n = 0;
    while (!(dev_k == 4 && dev_clk_low) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("pre_reset_data_oe", {31'h0, data_oe}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_clk_oe", {31'h0, clk_oe}, 32'h0);
    check("async_reset_data_oe", {31'h0, data_oe}, 32'h0);
    check("async_reset_rx_inhibit", {31'h0, rx_inh}, 32'h0);
    cpu_addr = ST_ADDR;
    #1 check("async_reset_status", rdata, 32'h0);
    cpu_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (dev_active && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("device_abort", {31'h0, dev_active}, 32'h0);
    exp_q.delete();
    send(8'hED);
    wait_idle("post_reset_idle", 400);
    read_expect("post_reset_status", ST_ADDR, 32'h2);

    // Random bytes with random ACK/NACK responses.
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      mode = int'($urandom_range(0, 1));
      dev_mode = mode;
      send(b);
      wait_idle("random_idle", 400);
      read_expect("random_status", ST_ADDR, (mode == 0) ? 32'h2 : 32'h4);
    end
    dev_mode = 0;

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
